// File: rtl/dac_sched_pkg.sv
// Shared definitions for the DAC frame scheduler: channel geometry, FSM
// state encoding and the channel-to-bit-offset helper.
package dac_sched_pkg;

  localparam int NUM_DEV = 8;
  localparam int NCH     = 2 * NUM_DEV;
  localparam int DW      = 16;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ARMED
  } state_t;

  function automatic int unsigned chan_slice(input int unsigned k);
    return k * DW;
  endfunction

endpackage

// File: rtl/dac_update_timer.sv
// Free-running update pacer: ticks every period+1 cycles while enabled.
// Also used for LDAC pacing on other boards.
module dac_update_timer #(
  parameter int PW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [PW-1:0] period,
  output logic          tick
);

  logic [PW-1:0] cnt;
  logic [PW-1:0] period_q;
  logic [PW-1:0] limit;

  // period is sampled at the start of each interval, so a new value only
  // applies from the next wrap onward
  always_comb begin
    limit = (cnt == '0) ? period : period_q;
    tick  = enable && (cnt == limit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      period_q <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else begin
      if (cnt == '0) period_q <= period;
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Collects an addressed sample frame into a shadow buffer and commits it to
// all DAC channels at once on each update tick.
module dac_frame_scheduler #(
  parameter  int NUM_DEV = dac_sched_pkg::NUM_DEV,
  parameter  int DW      = dac_sched_pkg::DW,
  parameter  int PW      = 32,
  parameter  int CW      = 16,
  localparam int NCH     = 2 * NUM_DEV,
  localparam int AW      = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [PW-1:0]     period,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [AW-1:0]     s_addr,
  input  logic [DW-1:0]     s_data,
  input  logic              s_last,
  output logic [NCH*DW-1:0] dac_out,
  output logic              update,
  output logic              underrun,
  output logic [CW-1:0]     underrun_count,
  output logic [CW-1:0]     frame_count
);

  import dac_sched_pkg::*;

  state_t            state;
  state_t            state_nxt;
  logic              tick;
  logic              beat;
  logic              commit;
  logic              miss;
  logic [NCH*DW-1:0] shadow;

  dac_update_timer #(.PW(PW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .period (period),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // tick already implies enable, so a tick outside ARMED is always an underrun
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = FILL;
      end
      FILL: begin
        s_ready = 1'b1;
        if (!enable)               state_nxt = IDLE;
        else if (s_valid && s_last) state_nxt = ARMED;
      end
      ARMED: begin
        if (!enable)   state_nxt = IDLE;
        else if (tick) state_nxt = FILL;
      end
      default: state_nxt = IDLE;
    endcase
    beat   = s_valid && s_ready;
    commit = tick && (state == ARMED);
    miss   = tick && (state != ARMED);
  end

  // out-of-range addresses match no channel and are silently dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (beat && (s_addr == AW'(k))) shadow[k*DW +: DW] <= s_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dac_out        <= '0;
      update         <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
      frame_count    <= '0;
    end else begin
      update   <= commit;
      underrun <= miss;
      if (commit) begin
        dac_out     <= shadow;
        frame_count <= frame_count + CW'(1);
      end
      if (miss && !(&underrun_count)) underrun_count <= underrun_count + CW'(1);
    end
  end

endmodule
